// File: rtl/addr_seq_gen.sv
// Register/bit address sequencer for serial register-file sweeps.
// Walks {rg_a, bit_a} up or down across a NUM_RG x BITS_PER_RG space, with optional wrap.
module addr_seq_gen #(
  parameter int NUM_RG      = 16,
  parameter int BITS_PER_RG = 4,
  parameter int RG_W        = (NUM_RG > 1) ? $clog2(NUM_RG) : 1,
  parameter int BIT_W       = (BITS_PER_RG > 1) ? $clog2(BITS_PER_RG) : 1
) (
  input  logic             tick,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic             dir,
  input  logic             wrap_md,
  input  logic             ld,
  input  logic [RG_W-1:0]  ld_rg,
  input  logic [BIT_W-1:0] ld_bit,
  output logic [RG_W-1:0]  rg_a,
  output logic [BIT_W-1:0] bit_a,
  output logic             busy,
  output logic             done,
  output logic             wrap_p,
  output logic             last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [RG_W-1:0]  RG_MAX  = RG_W'(NUM_RG - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BITS_PER_RG - 1);

  state_t            state_q, state_d;
  logic [RG_W-1:0]   rg_d, rg_start, rg_term, ld_rg_c;
  logic [BIT_W-1:0]  bit_d, bit_start, bit_term, ld_bit_c;
  logic              wrap_d;

  // Start and terminal are opposite corners of the address space, chosen by dir.
  always_comb begin
    rg_start  = dir ? RG_MAX  : '0;
    bit_start = dir ? BIT_MAX : '0;
    rg_term   = dir ? '0 : RG_MAX;
    bit_term  = dir ? '0 : BIT_MAX;
    ld_rg_c   = (ld_rg  > RG_MAX)  ? RG_MAX  : ld_rg;
    ld_bit_c  = (ld_bit > BIT_MAX) ? BIT_MAX : ld_bit;
  end

  assign last = (rg_a == rg_term) && (bit_a == bit_term);
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    rg_d    = rg_a;
    bit_d   = bit_a;
    wrap_d  = 1'b0;
    if (start && state_q != S_RUN) begin
      state_d = S_RUN;
      rg_d    = rg_start;
      bit_d   = bit_start;
    end else if (ld) begin
      rg_d  = ld_rg_c;
      bit_d = ld_bit_c;
    end else if (state_q == S_RUN && en) begin
      if (last) begin
        if (wrap_md) begin
          rg_d   = rg_start;
          bit_d  = bit_start;
          wrap_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end else if (!dir) begin
        if (bit_a == BIT_MAX) begin
          bit_d = '0;
          rg_d  = rg_a + RG_W'(1);
        end else begin
          bit_d = bit_a + BIT_W'(1);
        end
      end else begin
        // Borrow into the previous register when the bit index underflows.
        if (bit_a == '0) begin
          bit_d = BIT_MAX;
          rg_d  = rg_a - RG_W'(1);
        end else begin
          bit_d = bit_a - BIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge tick) begin
    if (clr) begin
      state_q <= S_IDLE;
      rg_a    <= '0;
      bit_a   <= '0;
      wrap_p  <= 1'b0;
    end else begin
      state_q <= state_d;
      rg_a    <= rg_d;
      bit_a   <= bit_d;
      wrap_p  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_addr_seq_gen.sv
// Scoreboard bench for addr_seq_gen: three geometries driven in lockstep against a
// linear-index reference model.
module tb_addr_seq_gen;

  typedef struct {
    int idx;
    int st;   // 0 idle, 1 run, 2 done
    bit wp;
  } model_t;

  typedef struct {
    int rg;
    int bt;
    bit busy;
    bit done;
    bit wp;
    bit last;
  } exp_t;

  logic       tick = 1'b1;
  logic       clr = 1'b1, start = 1'b0, en = 1'b0, dir = 1'b0, wrap_md = 1'b0, ld = 1'b0;
  logic [3:0] ld_rg_v = '0;
  logic [1:0] ld_bit_v = '0;

  logic [3:0] rg_a_a;
  logic [1:0] bit_a_a;
  logic [2:0] rg_a_b;
  logic [1:0] bit_a_b;
  logic [1:0] rg_a_c;
  logic [1:0] bit_a_c;
  logic busy_a, done_a, wrap_p_a, last_a;
  logic busy_b, done_b, wrap_p_b, last_b;
  logic busy_c, done_c, wrap_p_c, last_c;

  int checks = 0;
  int failures = 0;

  model_t ma = '{0, 0, 0}, mb = '{0, 0, 0}, mc = '{0, 0, 0};
  exp_t q_a[$], q_b[$], q_c[$];

  always #5 tick = ~tick;

  addr_seq_gen #(.NUM_RG(16), .BITS_PER_RG(4)) dut_a (
    .tick(tick), .clr(clr), .start(start), .en(en), .dir(dir), .wrap_md(wrap_md),
    .ld(ld), .ld_rg(ld_rg_v), .ld_bit(ld_bit_v),
    .rg_a(rg_a_a), .bit_a(bit_a_a), .busy(busy_a), .done(done_a),
    .wrap_p(wrap_p_a), .last(last_a));

  addr_seq_gen #(.NUM_RG(5), .BITS_PER_RG(3)) dut_b (
    .tick(tick), .clr(clr), .start(start), .en(en), .dir(dir), .wrap_md(wrap_md),
    .ld(ld), .ld_rg(ld_rg_v[2:0]), .ld_bit(ld_bit_v),
    .rg_a(rg_a_b), .bit_a(bit_a_b), .busy(busy_b), .done(done_b),
    .wrap_p(wrap_p_b), .last(last_b));

  addr_seq_gen #(.NUM_RG(3), .BITS_PER_RG(3)) dut_c (
    .tick(tick), .clr(clr), .start(start), .en(en), .dir(dir), .wrap_md(wrap_md),
    .ld(ld), .ld_rg(ld_rg_v[1:0]), .ld_bit(ld_bit_v),
    .rg_a(rg_a_c), .bit_a(bit_a_c), .busy(busy_c), .done(done_c),
    .wrap_p(wrap_p_c), .last(last_c));

  // Reference: the address is a single linear index rg*B+bit over 0..N*B-1.
  function automatic model_t mstep(input model_t m, input int n, input int b,
                                   input bit c, input bit s, input bit e, input bit d,
                                   input bit w, input bit l, input int ldr, input int ldb);
    model_t r;
    int tot;
    int term;
    r = m;
    r.wp = 1'b0;
    tot = n * b;
    term = d ? 0 : tot - 1;
    if (c) begin
      r.idx = 0;
      r.st = 0;
    end else if (s && m.st != 1) begin
      r.st = 1;
      r.idx = d ? tot - 1 : 0;
    end else if (l) begin
      r.idx = ((ldr > n - 1) ? n - 1 : ldr) * b + ((ldb > b - 1) ? b - 1 : ldb);
    end else if (m.st == 1 && e) begin
      if (m.idx == term) begin
        if (w) begin
          r.idx = d ? tot - 1 : 0;
          r.wp = 1'b1;
        end else begin
          r.st = 2;
        end
      end else begin
        r.idx = d ? m.idx - 1 : m.idx + 1;
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input model_t m, input int n, input int b, input bit d);
    exp_t e;
    e.rg = m.idx / b;
    e.bt = m.idx % b;
    e.busy = (m.st == 1);
    e.done = (m.st == 2);
    e.wp = m.wp;
    e.last = (m.idx == (d ? 0 : n * b - 1));
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [31:0] rg, input logic [31:0] bt,
                     input logic bsy, input logic dn, input logic wp, input logic lst);
    chk({nm, ".rg_a"}, rg, e.rg);
    chk({nm, ".bit_a"}, bt, e.bt);
    chk({nm, ".busy"}, {31'd0, bsy}, {31'd0, e.busy});
    chk({nm, ".done"}, {31'd0, dn}, {31'd0, e.done});
    chk({nm, ".wrap_p"}, {31'd0, wp}, {31'd0, e.wp});
    chk({nm, ".last"}, {31'd0, lst}, {31'd0, e.last});
  endtask

  // Drive one cycle of stimulus on the falling edge and queue the expected result.
  task automatic cyc(input bit c, input bit s, input bit e, input bit d, input bit w,
                     input bit l, input int ldr, input int ldb);
    @(negedge tick);
    clr = c; start = s; en = e; dir = d; wrap_md = w; ld = l;
    ld_rg_v = 4'(ldr);
    ld_bit_v = 2'(ldb);
    ma = mstep(ma, 16, 4, c, s, e, d, w, l, ldr & 15, ldb & 3);
    mb = mstep(mb, 5, 3, c, s, e, d, w, l, ldr & 7, ldb & 3);
    mc = mstep(mc, 3, 3, c, s, e, d, w, l, ldr & 3, ldb & 3);
    q_a.push_back(mk(ma, 16, 4, d));
    q_b.push_back(mk(mb, 5, 3, d));
    q_c.push_back(mk(mc, 3, 3, d));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge tick);
      #1;
      if (q_a.size() == 0 || q_b.size() == 0 || q_c.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=0 required=1 at t=%0t", $time);
      end else begin
        e = q_a.pop_front();
        cmp("a16x4", e, {28'd0, rg_a_a}, {30'd0, bit_a_a}, busy_a, done_a, wrap_p_a, last_a);
        e = q_b.pop_front();
        cmp("b5x3", e, {29'd0, rg_a_b}, {30'd0, bit_a_b}, busy_b, done_b, wrap_p_b, last_b);
        e = q_c.pop_front();
        cmp("c3x3", e, {30'd0, rg_a_c}, {30'd0, bit_a_c}, busy_c, done_c, wrap_p_c, last_c);
      end
    end
  end

  initial begin : driver
    bit rd, rw;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Full up sweep, one-shot, then hold in DONE.
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (70) cyc(0, 0, 1, 0, 0, 0, 0, 0);

    // Down sweep with wrap.
    cyc(0, 1, 1, 1, 1, 0, 0, 0);
    repeat (80) cyc(0, 0, 1, 1, 1, 0, 0, 0);

    // Clear mid-run at (5,2) on the 16x4 instance.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (22) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);

    // Load beats the same-cycle step.
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (13) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 9, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);

    // en gating and start ignored while running.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 1, 2, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);

    // Clamped load from IDLE; last with dir=0.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 3, 3);
    cyc(0, 0, 0, 0, 0, 1, 15, 3);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    // ld together with start: start wins.
    cyc(0, 1, 1, 0, 0, 1, 7, 2);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);

    rd = 0;
    rw = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 31) == 0) rd = ~rd;
      if ($urandom_range(0, 63) == 0) rw = ~rw;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0, rd, rw, $urandom_range(0, 19) == 0,
          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    @(posedge tick);
    #2;
    chk("scoreboard_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
